// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared widths, reset defaults and state type for the PDM clock generator
package pdm_pkg;

  localparam int CNT_W       = 16;
  localparam int DEC_W       = 8;
  localparam int DIV_DEFAULT = 1983;
  localparam int DEC_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/pdm_dec_counter.sv
// rtl/pdm_dec_counter.sv - counts rising-edge strobes and flags every ratio-th one
module pdm_dec_counter import pdm_pkg::*; #(
  parameter int DEC_W = pdm_pkg::DEC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [DEC_W-1:0] ratio,
  output logic             dec_stb
);

  logic [DEC_W-1:0] count;

  // ratio is never zero here; zero loads are rejected before reaching the active register
  assign dec_stb = tick && (count == ratio - 1'b1);

  // count ticks 0..ratio-1, wrapping on the strobe; clear restarts the sequence
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= dec_stb ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - programmable PDM microphone clock with glitch-free start/stop
module pdm_clk_gen import pdm_pkg::*; #(
  parameter int CNT_W       = pdm_pkg::CNT_W,
  parameter int DEC_W       = pdm_pkg::DEC_W,
  parameter int DIV_DEFAULT = pdm_pkg::DIV_DEFAULT,
  parameter int DEC_DEFAULT = pdm_pkg::DEC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_half,
  input  logic [DEC_W-1:0] dec_ratio,
  input  logic             cfg_load,
  output logic             pdm_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             dec_stb,
  output logic             running,
  output logic             cfg_err
);

  state_t           state, state_next;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] div_act, div_stage, div_next;
  logic [DEC_W-1:0] dec_act, dec_stage;
  logic             pending;
  logic             apply;
  logic             cfg_ok;
  logic             boundary;

  assign cfg_ok   = (dec_ratio != '0);
  assign boundary = (state != IDLE) && (hc == '0);
  assign rise_stb = boundary && !pdm_clk && (state == RUN);
  assign fall_stb = boundary && pdm_clk;
  assign running  = (state != IDLE);

  // staged config only switches in at rest or at the start of a low phase
  assign apply    = pending && ((state == IDLE) || fall_stb);
  assign div_next = apply ? div_stage : div_act;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: a stop always finishes the current phase, then parks with pdm_clk low
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = RUN;
      RUN:  if (!enable) state_next = STOP;
      STOP: begin
        if (hc == '0) state_next = IDLE;
        else if (enable) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // half-period counter and clock output; no rising edge is ever produced from STOP
  always_ff @(posedge clk) begin
    if (reset) begin
      hc      <= '0;
      pdm_clk <= 1'b0;
    end else if (state == IDLE) begin
      pdm_clk <= 1'b0;
      hc      <= enable ? div_next : '0;
    end else if (hc == '0) begin
      if (state == STOP) begin
        pdm_clk <= 1'b0;
        hc      <= '0;
      end else begin
        pdm_clk <= !pdm_clk;
        hc      <= div_next;
      end
    end else begin
      hc <= hc - 1'b1;
    end
  end

  // staging, pending flag, active config and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      div_act   <= CNT_W'(DIV_DEFAULT);
      dec_act   <= DEC_W'(DEC_DEFAULT);
      div_stage <= '0;
      dec_stage <= '0;
      pending   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (apply) begin
        div_act <= div_stage;
        dec_act <= dec_stage;
      end
      if (cfg_load) begin
        if (cfg_ok) begin
          div_stage <= div_half;
          dec_stage <= dec_ratio;
          cfg_err   <= 1'b0;
        end else begin
          cfg_err   <= 1'b1;
        end
      end
      pending <= (pending && !apply) || (cfg_load && cfg_ok);
    end
  end

  pdm_dec_counter #(
    .DEC_W (DEC_W)
  ) u_dec (
    .clk     (clk),
    .reset   (reset),
    .clear   (apply || (state_next == IDLE)),
    .tick    (rise_stb),
    .ratio   (dec_act),
    .dec_stb (dec_stb)
  );

endmodule

// File: tb/tb_pdm_clk_gen.sv
// tb/tb_pdm_clk_gen.sv - randomized and directed self-checking bench for pdm_clk_gen
module tb_pdm_clk_gen;

  localparam int CNT_W = 16;
  localparam int DEC_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [CNT_W-1:0] div_half;
  logic [DEC_W-1:0] dec_ratio;
  logic             cfg_load;
  logic             pdm_clk, rise_stb, fall_stb, dec_stb, running, cfg_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pdm_clk_gen dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .div_half  (div_half),
    .dec_ratio (dec_ratio),
    .cfg_load  (cfg_load),
    .pdm_clk   (pdm_clk),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .dec_stb   (dec_stb),
    .running   (running),
    .cfg_err   (cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ideal free-running waveform, k cycles after RUN entry: phases of div+1 cycles
  // starting low; every dec-th rising edge carries dec_stb.
  // Vector order: {pdm_clk, rise_stb, fall_stb, dec_stb, running}
  function automatic logic [4:0] ref_vec(int k, int div, int dec);
    int  p;
    int  r;
    logic lvl, last, rs, fs, ds;
    p    = k / (div + 1);
    lvl  = (p % 2) == 1;
    last = (k % (div + 1)) == div;
    rs   = last && !lvl;
    fs   = last && lvl;
    r    = p / 2 + 1;
    ds   = rs && ((r % dec) == 0);
    return {lvl, rs, fs, ds, 1'b1};
  endfunction

  // reset, load config in IDLE, then enable; returns at the first RUN cycle (k=0)
  task automatic start(input int div, input int dec);
    enable   = 1'b0;
    cfg_load = 1'b0;
    reset    = 1'b1;
    step();
    reset     = 1'b0;
    cfg_load  = 1'b1;
    div_half  = CNT_W'(div);
    dec_ratio = DEC_W'(dec);
    step();
    cfg_load = 1'b0;
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [5:0] got;
    enable    = 1'b1;
    cfg_load  = 1'b1;
    div_half  = '0;
    dec_ratio = '0;
    reset     = 1'b1;
    step();
    step();
    got = {pdm_clk, rise_stb, fall_stb, dec_stb, running, cfg_err};
    tests_run++;
    if (got !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b exp=%b", got, 6'b0);
    end
    reset    = 1'b0;
    enable   = 1'b0;
    cfg_load = 1'b0;
    step();
    step();
    got = {pdm_clk, rise_stb, fall_stb, dec_stb, running, cfg_err};
    tests_run++;
    if (got !== 6'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset got=%b exp=%b", got, 6'b0);
    end
  endtask

  task automatic test_div3();
    logic [4:0] got, exp;
    start(3, 64);
    for (int k = 0; k < 24; k++) begin
      got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
      exp = ref_vec(k, 3, 64);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL div3 k=%0d got=%b exp=%b", k, got, exp);
      end
      step();
    end
  endtask

  task automatic test_random_static();
    logic [4:0] got, exp;
    int div, dec, n;
    for (int it = 0; it < 8; it++) begin
      div = (it == 0) ? 0 : int'($urandom_range(0, 6));
      dec = (it == 0) ? 4 : int'($urandom_range(1, 5));
      start(div, dec);
      n = 4 * (div + 1) * dec + 6;
      for (int k = 0; k < n; k++) begin
        got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
        exp = ref_vec(k, div, dec);
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL random div=%0d dec=%0d k=%0d got=%b exp=%b", div, dec, k, got, exp);
        end
        step();
      end
    end
  endtask

  task automatic test_cfg_midphase();
    logic [4:0] got, exp;
    int j;
    start(5, 64);
    for (int k = 0; k < 36; k++) begin
      if (k < 12) begin
        exp = ref_vec(k, 5, 64);
      end else begin
        j   = k - 12;
        exp = ref_vec(j, 2, 64);
      end
      got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL cfg_midphase k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 8) begin
        cfg_load  = 1'b1;
        div_half  = CNT_W'(2);
        dec_ratio = DEC_W'(64);
      end else begin
        cfg_load = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_stop_high();
    logic [4:0] got, exp;
    start(7, 64);
    for (int k = 0; k < 32; k++) begin
      if (k < 16) exp = {k >= 8, k == 7, k == 15, 1'b0, 1'b1};
      else        exp = 5'b0;
      got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL stop_high k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 10) enable = 1'b0;
      step();
    end
  endtask

  task automatic test_stop_low();
    logic [4:0] got, exp;
    start(4, 2);
    for (int k = 0; k < 20; k++) begin
      exp = (k <= 4) ? 5'b00001 : 5'b0;
      got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL stop_low k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 1) enable = 1'b0;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    start(4, 2);
    for (int k = 0; k < 30; k++) begin
      exp = ref_vec(k, 4, 2);
      got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 1) enable = 1'b0;
      if (k == 2) enable = 1'b1;
      step();
    end
  endtask

  task automatic test_cfg_err();
    logic [4:0] got, exp;
    int wait_cnt;
    start(0, 3);
    enable    = 1'b0;
    step();
    step();
    cfg_load  = 1'b1;
    div_half  = CNT_W'(5);
    dec_ratio = '0;
    step();
    cfg_load  = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_err_set got=%b exp=1", cfg_err);
    end
    enable = 1'b1;
    step();
    for (int k = 0; k < 24; k++) begin
      exp = ref_vec(k, 0, 3);
      got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL cfg_err_unchanged k=%0d got=%b exp=%b", k, got, exp);
      end
      step();
    end
    tests_run++;
    if (cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_err_sticky got=%b exp=1", cfg_err);
    end
    enable   = 1'b0;
    wait_cnt = 0;
    while (running && wait_cnt < 10) begin
      step();
      wait_cnt++;
    end
    tests_run++;
    if (running !== 1'b0) begin
      tests_failed++;
      $display("FAIL cfg_err_stop_timeout got=%b exp=0", running);
    end
    cfg_load  = 1'b1;
    div_half  = CNT_W'(1);
    dec_ratio = DEC_W'(2);
    step();
    cfg_load = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL cfg_err_clear got=%b exp=0", cfg_err);
    end
  endtask

  task automatic test_reset_midrun();
    logic [4:0] got, exp;
    start(5, 2);
    for (int k = 0; k < 8; k++) step();
    tests_run++;
    if (pdm_clk !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_pre got=%b exp=1", pdm_clk);
    end
    reset = 1'b1;
    step();
    got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
    tests_run++;
    if (got !== 5'b0 || cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid got=%b/%b exp=00000/0", got, cfg_err);
    end
    reset = 1'b0;
    step();
    for (int k = 0; k < 1990; k++) begin
      exp = ref_vec(k, 1983, 64);
      got = {pdm_clk, rise_stb, fall_stb, dec_stb, running};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reset_default k=%0d got=%b exp=%b", k, got, exp);
      end
      step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    cfg_load  = 1'b0;
    div_half  = '0;
    dec_ratio = '0;
    test_reset();
    test_div3();
    test_random_static();
    test_cfg_midphase();
    test_stop_high();
    test_stop_low();
    test_back_to_back();
    test_cfg_err();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
